// File: rtl/eth_phy_10g_tx_if_if.sv
// Block-level bus between the 64b/66b encoder and the SERDES transmit path.
// master drives encoded blocks and observes SERDES data; slave is the PHY TX interface.
interface eth_phy_10g_tx_if_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned HDR_WIDTH  = 2
);
    logic [DATA_WIDTH-1:0] encoded_tx_data;
    logic [HDR_WIDTH-1:0]  encoded_tx_hdr;
    logic [DATA_WIDTH-1:0] serdes_tx_data;
    logic [HDR_WIDTH-1:0]  serdes_tx_hdr;

    modport master (
        output encoded_tx_data,
        output encoded_tx_hdr,
        input  serdes_tx_data,
        input  serdes_tx_hdr
    );

    modport slave (
        input  encoded_tx_data,
        input  encoded_tx_hdr,
        output serdes_tx_data,
        output serdes_tx_hdr
    );
endinterface

// File: rtl/eth_phy_10g_tx_if.sv
// 10GBASE-R transmit interface: 64b/66b payload scrambler, optional bit reversal and SERDES pipeline.
// Define ETH_PHY_10G_TX_PRBS31_EN to compile in the PRBS31 test-pattern generator.
module eth_phy_10g_tx_if #(
    parameter int unsigned DATA_WIDTH        = 64,
    parameter int unsigned HDR_WIDTH         = 2,
    parameter bit          BIT_REVERSE       = 1'b0,
    parameter bit          SCRAMBLER_DISABLE = 1'b0,
    parameter int unsigned SERDES_PIPELINE   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    eth_phy_10g_tx_if_if.slave   tx,
    input  logic                 cfg_tx_prbs31_enable
);

    if (DATA_WIDTH != 64) begin : g_chk_data_width
        $error("eth_phy_10g_tx_if: DATA_WIDTH must be 64");
    end
    if (HDR_WIDTH != 2) begin : g_chk_hdr_width
        $error("eth_phy_10g_tx_if: HDR_WIDTH must be 2");
    end

    logic [57:0]           scr_state;
    logic [57:0]           scr_state_next;
    logic [DATA_WIDTH-1:0] scr_data;

    // Bit 0 is transmitted first; state[k] holds the scrambled bit k+1 positions earlier.
    always_comb begin
        scr_state_next = scr_state;
        scr_data       = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            scr_data[i]    = tx.encoded_tx_data[i] ^ scr_state_next[38] ^ scr_state_next[57];
            scr_state_next = {scr_state_next[56:0], scr_data[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scr_state <= '1;
        end else begin
            scr_state <= scr_state_next;
        end
    end

    logic [DATA_WIDTH-1:0] mux_data;
    logic [HDR_WIDTH-1:0]  mux_hdr;

`ifdef ETH_PHY_10G_TX_PRBS31_EN
    logic [30:0] prbs_state;
    logic [30:0] prbs_state_next;
    logic [65:0] prbs_word;
    logic        prbs_bit;

    always_comb begin
        prbs_state_next = prbs_state;
        prbs_word       = '0;
        prbs_bit        = 1'b0;
        for (int unsigned i = 0; i < 66; i++) begin
            prbs_bit        = prbs_state_next[30] ^ prbs_state_next[27];
            prbs_word[i]    = ~prbs_bit;
            prbs_state_next = {prbs_state_next[29:0], prbs_bit};
        end
    end

    // Generator only advances while selected, so the pattern resumes where it paused.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prbs_state <= 31'h7FFFFFFF;
        end else if (cfg_tx_prbs31_enable) begin
            prbs_state <= prbs_state_next;
        end
    end

    always_comb begin
        mux_data = SCRAMBLER_DISABLE ? tx.encoded_tx_data : scr_data;
        mux_hdr  = tx.encoded_tx_hdr;
        if (cfg_tx_prbs31_enable) begin
            mux_data = prbs_word[65:2];
            mux_hdr  = prbs_word[1:0];
        end
    end
`else
    logic unused_cfg_prbs;
    assign unused_cfg_prbs = cfg_tx_prbs31_enable;

    always_comb begin
        mux_data = SCRAMBLER_DISABLE ? tx.encoded_tx_data : scr_data;
        mux_hdr  = tx.encoded_tx_hdr;
    end
`endif

    logic [DATA_WIDTH-1:0] ord_data;
    logic [HDR_WIDTH-1:0]  ord_hdr;

    always_comb begin
        ord_data = mux_data;
        ord_hdr  = mux_hdr;
        if (BIT_REVERSE) begin
            for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
                ord_data[i] = mux_data[DATA_WIDTH-1-i];
            end
            for (int unsigned i = 0; i < HDR_WIDTH; i++) begin
                ord_hdr[i] = mux_hdr[HDR_WIDTH-1-i];
            end
        end
    end

    // Stage 0 is the mandatory output register; stages 1..SERDES_PIPELINE are extra.
    logic [DATA_WIDTH-1:0] pipe_data [SERDES_PIPELINE+1];
    logic [HDR_WIDTH-1:0]  pipe_hdr  [SERDES_PIPELINE+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SERDES_PIPELINE + 1; i++) begin
                pipe_data[i] <= '0;
                pipe_hdr[i]  <= '0;
            end
        end else begin
            pipe_data[0] <= ord_data;
            pipe_hdr[0]  <= ord_hdr;
            for (int unsigned i = 1; i < SERDES_PIPELINE + 1; i++) begin
                pipe_data[i] <= pipe_data[i-1];
                pipe_hdr[i]  <= pipe_hdr[i-1];
            end
        end
    end

    assign tx.serdes_tx_data = pipe_data[SERDES_PIPELINE];
    assign tx.serdes_tx_hdr  = pipe_hdr[SERDES_PIPELINE];

endmodule
